// File: rtl/fpsu_div_sched_pkg.sv
// Shared types and constants for the FP divide/sqrt scheduler.
package fpsu_div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned NPORT     = 3;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned LAT_S_DEF = 12;
    localparam int unsigned LAT_D_DEF = 20;
    localparam int unsigned TAG_W_DEF = 14;

    localparam logic [1:0] P_U1 = 2'd0;
    localparam logic [1:0] P_U3 = 2'd1;
    localparam logic [1:0] P_U5 = 2'd2;

    // Round-robin successor of a port index (u1 -> u3 -> u5 -> u1).
    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        return (idx >= P_U5) ? P_U1 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/fpsu_div_sched_rr_arb3.sv
// Three-way round-robin pick: the first requester at or after ptr_i wins.
module fpsu_div_sched_rr_arb3
    import fpsu_div_sched_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] gnt_oh_o,
    output logic [1:0] idx_o,
    output logic       any_o
);

    logic [1:0] cand;

    // Scan from lowest priority to highest so the pointer position wins last.
    always_comb begin
        gnt_oh_o = '0;
        idx_o    = P_U1;
        any_o    = 1'b0;
        cand     = P_U1;
        for (int k = 2; k >= 0; k--) begin
            cand = 2'((int'(ptr_i) + k) % 3);
            if (req_i[cand]) begin
                gnt_oh_o = 3'b001 << cand;
                idx_o    = cand;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpsu_div_sched.sv
// Shares one iterative FP divide/sqrt datapath between issue ports u1/u3/u5
// and returns completions on the owner's ret slot when the add pipe leaves it free.
module fpsu_div_sched
    import fpsu_div_sched_pkg::*;
#(
    parameter int unsigned LAT_S = LAT_S_DEF,
    parameter int unsigned LAT_D = LAT_D_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             u1_req,
    input  logic             u1_dbl,
    input  logic [TAG_W-1:0] u1_tag,
    output logic             u1_gnt,
    input  logic             u1_pipe_ret,
    output logic [TAG_W-1:0] u1_ret,
    output logic             u1_ret_en,
    input  logic             u3_req,
    input  logic             u3_dbl,
    input  logic [TAG_W-1:0] u3_tag,
    output logic             u3_gnt,
    input  logic             u3_pipe_ret,
    output logic [TAG_W-1:0] u3_ret,
    output logic             u3_ret_en,
    input  logic             u5_req,
    input  logic             u5_dbl,
    input  logic [TAG_W-1:0] u5_tag,
    output logic             u5_gnt,
    input  logic             u5_pipe_ret,
    output logic [TAG_W-1:0] u5_ret,
    output logic             u5_ret_en,
    input  logic             flush,
    output logic             div_start,
    output logic [1:0]       div_sel,
    output logic             div_dbl,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAT_S_M1 = CNT_W'(LAT_S - 1);
    localparam logic [CNT_W-1:0] LAT_D_M1 = CNT_W'(LAT_D - 1);

    logic [NPORT-1:0] req_vec;
    logic [NPORT-1:0] dbl_vec;
    logic [NPORT-1:0] pipe_vec;
    logic [TAG_W-1:0] tag_vec [NPORT];

    assign req_vec  = {u5_req, u3_req, u1_req};
    assign dbl_vec  = {u5_dbl, u3_dbl, u1_dbl};
    assign pipe_vec = {u5_pipe_ret, u3_pipe_ret, u1_pipe_ret};
    assign tag_vec[P_U1] = u1_tag;
    assign tag_vec[P_U3] = u3_tag;
    assign tag_vec[P_U5] = u5_tag;

    logic [NPORT-1:0] win_oh;
    logic [1:0]       win_idx;
    logic             win_any;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rr_q, rr_d;
    logic [1:0]       owner_q, owner_d;
    logic             dbl_q, dbl_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             drain_q, drain_d;
    logic             busy_q;

    logic [NPORT-1:0] gnt_c;
    logic [NPORT-1:0] ret_en_c;
    logic             start_c;
    logic [1:0]       sel_c;
    logic             sel_dbl_c;
    logic             kill_c;

    fpsu_div_sched_rr_arb3 u_rr_arb3 (
        .req_i    (req_vec),
        .ptr_i    (rr_q),
        .gnt_oh_o (win_oh),
        .idx_o    (win_idx),
        .any_o    (win_any)
    );

    // Reset and flush both cancel anything this cycle would have issued or retired.
    assign kill_c = rst | flush;

    // Next-state and same-cycle handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        dbl_d     = dbl_q;
        tag_d     = tag_q;
        drain_d   = 1'b0;
        gnt_c     = '0;
        ret_en_c  = '0;
        start_c   = 1'b0;
        sel_c     = P_U1;
        sel_dbl_c = 1'b0;

        case (state_q)
            IDLE: begin
                // The cycle right after a retire is a bubble: no new start.
                if (win_any && !drain_q && !kill_c) begin
                    gnt_c     = win_oh;
                    start_c   = 1'b1;
                    sel_c     = win_idx;
                    sel_dbl_c = dbl_vec[win_idx];
                    owner_d   = win_idx;
                    dbl_d     = dbl_vec[win_idx];
                    tag_d     = tag_vec[win_idx];
                    cnt_d     = dbl_vec[win_idx] ? LAT_D_M1 : LAT_S_M1;
                    rr_d      = next_ptr(win_idx);
                    state_d   = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Retry every cycle until the add pipe leaves the owner's slot free.
                if (!pipe_vec[owner_q]) begin
                    if (!kill_c) begin
                        ret_en_c[owner_q] = 1'b1;
                    end
                    drain_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d = IDLE;
            drain_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= P_U1;
            owner_q <= P_U1;
            dbl_q   <= 1'b0;
            tag_q   <= '0;
            drain_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            dbl_q   <= dbl_d;
            tag_q   <= tag_d;
            drain_q <= drain_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign u1_gnt    = gnt_c[P_U1];
    assign u3_gnt    = gnt_c[P_U3];
    assign u5_gnt    = gnt_c[P_U5];
    assign u1_ret_en = ret_en_c[P_U1];
    assign u3_ret_en = ret_en_c[P_U3];
    assign u5_ret_en = ret_en_c[P_U5];
    assign u1_ret    = ret_en_c[P_U1] ? tag_q : '0;
    assign u3_ret    = ret_en_c[P_U3] ? tag_q : '0;
    assign u5_ret    = ret_en_c[P_U5] ? tag_q : '0;
    assign div_start = start_c;
    assign div_sel   = sel_c;
    assign div_dbl   = sel_dbl_c;
    assign busy      = busy_q;

    lat_range_a: assert property (@(posedge clk)
        (LAT_S >= 2) && (LAT_S <= 63) && (LAT_D >= 2) && (LAT_D <= 63));

    // The running count can never exceed the load value for the latched precision.
    cnt_bound_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == RUN) |-> (cnt_q <= (dbl_q ? LAT_D_M1 : LAT_S_M1)));

endmodule

// File: tb/tb_fpsu_div_sched.sv
// Directed plus randomized bench for the FP divide/sqrt scheduler.
module tb_fpsu_div_sched;

    localparam int LAT_S = 12;
    localparam int LAT_D = 20;
    localparam int TAG_W = 14;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [2:0]       req_m;
    logic [2:0]       dbl_m;
    logic [2:0]       pipe_m;
    logic [TAG_W-1:0] tag_m [3];

    logic             u1_gnt, u3_gnt, u5_gnt;
    logic             u1_ret_en, u3_ret_en, u5_ret_en;
    logic [TAG_W-1:0] u1_ret, u3_ret, u5_ret;
    logic             div_start, div_dbl, busy;
    logic [1:0]       div_sel;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int model_ptr = 0;
    int grant_cyc = 0;

    fpsu_div_sched #(.LAT_S(LAT_S), .LAT_D(LAT_D), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .u1_req      (req_m[0]),
        .u1_dbl      (dbl_m[0]),
        .u1_tag      (tag_m[0]),
        .u1_gnt      (u1_gnt),
        .u1_pipe_ret (pipe_m[0]),
        .u1_ret      (u1_ret),
        .u1_ret_en   (u1_ret_en),
        .u3_req      (req_m[1]),
        .u3_dbl      (dbl_m[1]),
        .u3_tag      (tag_m[1]),
        .u3_gnt      (u3_gnt),
        .u3_pipe_ret (pipe_m[1]),
        .u3_ret      (u3_ret),
        .u3_ret_en   (u3_ret_en),
        .u5_req      (req_m[2]),
        .u5_dbl      (dbl_m[2]),
        .u5_tag      (tag_m[2]),
        .u5_gnt      (u5_gnt),
        .u5_pipe_ret (pipe_m[2]),
        .u5_ret      (u5_ret),
        .u5_ret_en   (u5_ret_en),
        .flush       (flush),
        .div_start   (div_start),
        .div_sel     (div_sel),
        .div_dbl     (div_dbl),
        .busy        (busy)
    );

    wire [2:0]  gnt_v = {u5_gnt, u3_gnt, u1_gnt};
    wire [2:0]  ren_v = {u5_ret_en, u3_ret_en, u1_ret_en};
    wire [41:0] ret_v = {u5_ret, u3_ret, u1_ret};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Reference arbitration: first requesting port walking u1->u3->u5 from ptr.
    function automatic int pick(input logic [2:0] r, input int ptr);
        for (int k = 0; k < 3; k++) begin
            int p;
            p = (ptr + k) % 3;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    task automatic reset_dut();
        rst = 1'b1; flush = 1'b0; req_m = '0; dbl_m = '0; pipe_m = '0;
        for (int i = 0; i < 3; i++) tag_m[i] = '0;
        step();
        mid();
        chk("rst_ctl", {gnt_v, ren_v, div_start, div_sel, div_dbl, busy}, 64'd0);
        chk("rst_ret", ret_v, 64'd0);
        step();
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Expect a grant in the current cycle to the reference winner.
    task automatic do_grant(output int port);
        mid();
        port = pick(req_m, model_ptr);
        if (port < 0) begin
            chk("grant_expected_requester", 64'd0, 64'd1);
            port = 0;
        end
        chk("gnt_vec", gnt_v, 64'd1 << port);
        chk("div_start", div_start, 64'd1);
        chk("div_sel", div_sel, port);
        chk("div_dbl", div_dbl, dbl_m[port]);
        chk("busy_at_grant", busy, 64'd0);
        grant_cyc = cyc;
        model_ptr = (port + 1) % 3;
    endtask

    // Follow an op from its grant cycle through retire and the idle bubble.
    // The owner's add-pipe slot is busy on relative cycles bf..bt.
    task automatic follow_op(input int port, input int bf, input int bt);
        int lat, rcyc;
        logic [TAG_W-1:0] tag;
        logic [41:0] exp_ret;
        tag  = tag_m[port];
        lat  = dbl_m[port] ? LAT_D : LAT_S;
        rcyc = lat;
        while (rcyc >= bf && rcyc <= bt) rcyc++;
        for (int r = 1; r <= rcyc + 1; r++) begin
            step();
            if (r == 1) req_m[port] = 1'b0;
            for (int o = 0; o < 3; o++) begin
                if (o == port) pipe_m[o] = (r >= bf && r <= bt);
                else           pipe_m[o] = 1'($urandom_range(0, 1));
            end
            mid();
            exp_ret = '0;
            if (r == rcyc) exp_ret[port*TAG_W +: TAG_W] = tag;
            chk("ret_en", ren_v, (r == rcyc) ? (64'd1 << port) : 64'd0);
            chk("ret_tag", ret_v, exp_ret);
            chk("no_gnt_busy", {gnt_v, div_start}, 64'd0);
            chk("busy", busy, (r <= rcyc) ? 64'd1 : 64'd0);
        end
        step();
        pipe_m = '0;
    endtask

    initial begin
        int w, prev;
        rst = 1'b1;
        reset_dut();

        // Single u3 single-precision op.
        req_m[1] = 1'b1; dbl_m[1] = 1'b0; tag_m[1] = 14'h155;
        do_grant(w);
        follow_op(w, 99, 0);

        // u5 single with its ret slot taken on relative cycles 12..14.
        req_m[2] = 1'b1; dbl_m[2] = 1'b0; tag_m[2] = TAG_W'($urandom);
        do_grant(w);
        chk("u5_owner", w, 64'd2);
        follow_op(w, 12, 14);

        // All three double requests held together: u1, u3, u5 every LAT_D+2.
        reset_dut();
        req_m = 3'b111; dbl_m = 3'b111;
        for (int i = 0; i < 3; i++) tag_m[i] = TAG_W'($urandom);
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            do_grant(w);
            chk("rr_order", w, i);
            if (i > 0) chk("issue_interval", grant_cyc - prev, LAT_D + 2);
            prev = grant_cyc;
            follow_op(w, 99, 0);
        end

        // Flush in the middle of a u1 op; pending u3 wins next, then u1.
        reset_dut();
        req_m[0] = 1'b1; dbl_m[0] = 1'b0; tag_m[0] = TAG_W'($urandom);
        do_grant(w);
        for (int r = 1; r <= 5; r++) begin
            step();
            if (r == 1) begin
                req_m[0] = 1'b0; req_m[1] = 1'b1;
                dbl_m[1] = 1'($urandom_range(0, 1)); tag_m[1] = TAG_W'($urandom);
            end
            if (r == 5) flush = 1'b1;
            mid();
            chk("flush_pre_quiet", {gnt_v, div_start, ren_v}, 64'd0);
            chk("flush_pre_busy", busy, 64'd1);
        end
        step();
        flush = 1'b0; req_m[0] = 1'b1;
        do_grant(w);
        chk("flush_rr_kept", w, 64'd1);
        follow_op(w, 99, 0);
        do_grant(w);
        follow_op(w, 99, 0);

        // Flush coinciding with a would-be grant suppresses it for one cycle.
        req_m[2] = 1'b1; dbl_m[2] = 1'b1; tag_m[2] = TAG_W'($urandom); flush = 1'b1;
        mid();
        chk("flush_gnt_suppressed", {gnt_v, div_start}, 64'd0);
        step();
        flush = 1'b0;
        do_grant(w);
        follow_op(w, 99, 0);

        // Reset while DONE is blocked by the add pipe; held requests regrant from u1.
        reset_dut();
        req_m[1] = 1'b1; dbl_m[1] = 1'b0; tag_m[1] = TAG_W'($urandom);
        do_grant(w);
        for (int r = 1; r <= 14; r++) begin
            step();
            if (r == 1) begin
                req_m = 3'b101; dbl_m[0] = 1'b0; dbl_m[2] = 1'b1;
                tag_m[0] = TAG_W'($urandom); tag_m[2] = TAG_W'($urandom);
            end
            pipe_m[1] = (r >= 12);
            if (r >= 13) rst = 1'b1;
            mid();
            chk("rst_blk_quiet", {gnt_v, div_start, ren_v}, 64'd0);
        end
        chk("rst_out_ctl", {gnt_v, ren_v, div_start, div_sel, div_dbl, busy}, 64'd0);
        chk("rst_out_ret", ret_v, 64'd0);
        step();
        rst = 1'b0; pipe_m = '0; model_ptr = 0;
        do_grant(w);
        chk("rst_regrant_u1", w, 64'd0);
        follow_op(w, 99, 0);
        do_grant(w);
        follow_op(w, 99, 0);

        // Randomized request mixes and add-pipe slot collisions.
        for (int it = 0; it < 30; it++) begin
            int bf, bt, lat;
            if (req_m == 3'b000) begin
                req_m = 3'($urandom_range(1, 7));
                dbl_m = 3'($urandom_range(0, 7));
                for (int i = 0; i < 3; i++) tag_m[i] = TAG_W'($urandom);
            end
            do_grant(w);
            lat = dbl_m[w] ? LAT_D : LAT_S;
            if ($urandom_range(0, 1) == 1) begin
                bf = lat - 1 + int'($urandom_range(0, 2));
                bt = bf + int'($urandom_range(0, 3));
            end else begin
                bf = 99; bt = 0;
            end
            follow_op(w, bf, bt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
